// File: rtl/life_run_ctrl.sv
// life_run_ctrl: grid register plus run/dump sequencing for the 8x8 Life engine.
// IDLE loads rows, RUN commits one generation per clock from the external
// evolve datapath, DUMP streams the frozen grid out row by row.
// Optional still-life detection: define LIFE_STABLE_DETECT_EN.
module life_run_ctrl #(
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [2:0]       load_row,
  input  logic [7:0]       load_data,
  input  logic             start,
  input  logic [GEN_W-1:0] gen_target,
  input  logic             stop,
  output logic [63:0]      grid_q,
  input  logic [63:0]      grid_evolve,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [2:0]       rd_row,
  output logic [7:0]       rd_data
);

  typedef enum logic [1:0] {IDLE, RUN, DUMP} state_t;

  state_t           state, state_n;
  logic [GEN_W-1:0] target;
  logic [GEN_W-1:0] cnt_inc;
  logic             still;
  logic             rd_fire;

  assign cnt_inc    = gen_count + 1'b1;
  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rd_valid   = (state == DUMP);
  assign rd_fire    = rd_valid && rd_ready;
  // done is the row-7 handshake itself, so busy drops on the following cycle
  assign done       = rd_fire && (rd_row == 3'd7);
  assign rd_data    = grid_q[{rd_row, 3'b000} +: 8];

`ifdef LIFE_STABLE_DETECT_EN
  logic stable_r;
  assign still  = (grid_evolve == grid_q);
  assign stable = stable_r;

  // Sticky still-life flag: cleared by an accepted start, set when RUN ends on one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_r <= 1'b0;
    end else if (state == IDLE && start && !load_valid) begin
      stable_r <= 1'b0;
    end else if (state == RUN && !stop && still) begin
      stable_r <= 1'b1;
    end
  end
`else
  assign still  = 1'b0;
  assign stable = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: stop beats still-life beats commit; target 0 never ends on count
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start && !load_valid) state_n = RUN;
      RUN: begin
        if (stop || still)                           state_n = DUMP;
        else if (target != '0 && cnt_inc == target)  state_n = DUMP;
      end
      DUMP: if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grid, counter, target and read pointer; grid only moves on load or commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grid_q    <= '0;
      gen_count <= '0;
      target    <= '0;
      rd_row    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            grid_q[{load_row, 3'b000} +: 8] <= load_data;
          end else if (start) begin
            target    <= gen_target;
            gen_count <= '0;
          end
        end
        RUN: begin
          if (!stop && !still) begin
            grid_q    <= grid_evolve;
            gen_count <= cnt_inc;
          end
        end
        DUMP: begin
          // wraps 7 -> 0, leaving the pointer ready for the next dump
          if (rd_fire) rd_row <= rd_row + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_run_ctrl.sv
// tb_life_run_ctrl: scoreboard bench. A behavioural Life model supplies the
// evolve datapath and predicts each run's outcome; a monitor checks DUMP rows.
module tb_life_run_ctrl;

  localparam int GEN_W = 16;
`ifdef LIFE_STABLE_DETECT_EN
  localparam bit STAB = 1'b1;
`else
  localparam bit STAB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid, load_ready;
  logic [2:0]       load_row;
  logic [7:0]       load_data;
  logic             start, stop;
  logic [GEN_W-1:0] gen_target;
  logic [63:0]      grid_q, grid_evolve;
  logic             busy, done, stable;
  logic [GEN_W-1:0] gen_count;
  logic             rd_valid, rd_ready;
  logic [2:0]       rd_row;
  logic [7:0]       rd_data;

  life_run_ctrl #(.GEN_W(GEN_W)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_row(load_row), .load_data(load_data),
    .start(start), .gen_target(gen_target), .stop(stop),
    .grid_q(grid_q), .grid_evolve(grid_evolve),
    .busy(busy), .done(done), .stable(stable), .gen_count(gen_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Life rule on a bounded 8x8 board; cells beyond the edge are dead
  function automatic logic [63:0] life_step(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int k;
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8)
              k += int'(g[(r+dr)*8 + c+dc]);
        n[r*8+c] = (k == 3) || (g[r*8+c] && k == 2);
      end
    return n;
  endfunction

  assign grid_evolve = life_step(grid_q);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Run outcome from the rules: generations advance until stop, still life,
  // or the target count is reached
  function automatic void model(input logic [63:0] g0, input int tgt, input int stop_at,
                                output logic [63:0] g, output int cnt, output bit st,
                                output int rc);
    logic [63:0] nx;
    g = g0; cnt = 0; st = 1'b0; rc = 0;
    while (rc < 5000) begin
      rc++;
      if (rc == stop_at) break;
      nx = life_step(g);
      if (STAB && nx == g) begin st = 1'b1; break; end
      g = nx;
      cnt++;
      if (tgt != 0 && cnt == tgt) break;
    end
  endfunction

  typedef struct { logic [2:0] row; logic [7:0] data; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  bit   stall_prev = 1'b0;
  logic [2:0] prev_row;
  logic [7:0] prev_data;

  // Monitor: every accepted read-out row is popped and compared
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && rd_valid) begin
        chk("stall_row", {61'd0, rd_row}, {61'd0, prev_row});
        chk("stall_data", {56'd0, rd_data}, {56'd0, prev_data});
      end
      if (rd_valid && rd_ready) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_row actual=%0d required=none", rd_row);
        end else begin
          mon_e = sbq.pop_front();
          chk("rd_row", {61'd0, rd_row}, {61'd0, mon_e.row});
          chk("rd_data", {56'd0, rd_data}, {56'd0, mon_e.data});
          chk("done_on_xfer", {63'd0, done}, {63'd0, (mon_e.row == 3'd7)});
        end
      end else if (rd_valid) begin
        chk("done_stalled", {63'd0, done}, 64'd0);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      stall_prev = rd_valid && !rd_ready;
      prev_row   = rd_row;
      prev_data  = rd_data;
    end
  end

  task automatic load_grid(input logic [63:0] g);
    for (int r = 0; r < 8; r++) begin
      load_valid = 1'b1; load_row = 3'(r); load_data = g[r*8 +: 8];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    chk("load_grid", grid_q, g);
  endtask

  // bp: 0 = rd_ready held high, 1 = toggle each cycle, 2 = random
  task automatic run(input string tag, input logic [63:0] g0, input int tgt,
                     input int stop_at, input int bp);
    logic [63:0] eg; int ecnt, erc, k, start_cyc, d0; bit est;
    load_grid(g0);
    model(g0, tgt, stop_at, eg, ecnt, est, erc);
    for (int r = 0; r < 8; r++) sbq.push_back('{row: 3'(r), data: eg[r*8 +: 8]});
    rd_ready = 1'b1;
    d0 = done_cnt;
    gen_target = GEN_W'(tgt); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
    k = 1;
    while (!rd_valid && k < 6000) begin
      stop = (k == stop_at);
      @(posedge clk); #1;
      stop = 1'b0;
      k++;
    end
    chk({tag, "_run_cycles"}, 64'(k - 1), 64'(erc));
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      if (bp == 1) rd_ready = ~rd_ready;
      else if (bp == 2) rd_ready = 1'($urandom);
      @(posedge clk); #1;
      k++;
    end
    rd_ready = 1'b1;
    chk({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
    if (bp == 0) chk({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'(erc + 8));
    chk({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
    chk({tag, "_gen_count"}, 64'(gen_count), 64'(ecnt));
    chk({tag, "_stable"}, {63'd0, stable}, {63'd0, est});
    chk({tag, "_grid"}, grid_q, eg);
    chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  logic [63:0] blinker, blockp, rg;

  initial begin
    blinker = 64'h1C << 24;
    blockp  = (64'h18 << 24) | (64'h18 << 32);
    reset = 1'b0; load_valid = 1'b0; load_row = '0; load_data = '0;
    start = 1'b0; stop = 1'b0; gen_target = '0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grid", grid_q, 64'd0);
    chk("rst_flags", {58'd0, busy, done, stable, rd_valid, load_ready, 1'b0},
        {58'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("rst_cnt", {45'd0, gen_count, rd_row}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run("blink1", blinker, 1, 0, 0);
    run("blink2", blinker, 2, 0, 0);
    run("block5", blockp, 5, 0, 0);
    run("blink_stop", blinker, 0, 7, 0);
    run("bp_toggle", blinker, 3, 0, 1);
    for (int i = 0; i < 16; i++) begin
      rg = {$urandom, $urandom};
      if (i % 2 == 0) run("rand_tgt", rg, int'($urandom_range(1, 12)), 0, int'($urandom_range(0, 2)));
      else            run("rand_stop", rg, int'($urandom_range(0, 6)), int'($urandom_range(1, 10)),
                          int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a long run
    load_grid(blinker);
    gen_target = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_grid", grid_q, 64'd0);
    chk("mid_rst_flags", {59'd0, busy, done, stable, rd_valid, load_ready}, 64'd1);
    chk("mid_rst_cnt", {45'd0, gen_count, rd_row}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run("post_rst", blinker, 4, 0, 0);

    // start alongside a load: the load wins and no run begins
    load_valid = 1'b1; load_row = 3'd5; load_data = 8'hA5; start = 1'b1; gen_target = 16'd3;
    @(posedge clk); #1;
    load_valid = 1'b0; start = 1'b0;
    chk("ld_start_row", {56'd0, grid_q[47:40]}, 64'hA5);
    chk("ld_start_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("ld_start_idle", {62'd0, busy, rd_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
